// File: rtl/mat_mult_lanes_pkg.sv
// rtl/mat_mult_lanes_pkg.sv - shared types and fixed-point helpers for the lane matrix multiplier
package mat_mult_lanes_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int RS_W = 128;
  localparam logic signed [RS_W-1:0] RS_ONE = 1;

  function automatic int dim_w(input int max_dim);
    return (max_dim > 2) ? $clog2(max_dim) : 1;
  endfunction

  function automatic int acc_w(input int w, input int dw);
    return 2 * w + dw;
  endfunction

  // Round half up at the binary point, then clamp into a signed w-bit range.
  function automatic logic signed [RS_W-1:0] round_sat(input logic signed [RS_W-1:0] acc,
                                                       input int f_width, input int w);
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    r = acc;
    if (f_width > 0) r = (acc + (RS_ONE <<< (f_width - 1))) >>> f_width;
    hi = (RS_ONE <<< (w - 1)) - RS_ONE;
    lo = -(RS_ONE <<< (w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/mat_mult_lane_mac.sv
// rtl/mat_mult_lane_mac.sv - one output-column lane: signed multiply, load/accumulate, round and saturate
module mat_mult_lane_mac
  import mat_mult_lanes_pkg::*;
#(
  parameter int W       = 32,
  parameter int ACC_W   = 71,
  parameter int F_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         first,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result
);

  logic signed [2*W-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = {{(ACC_W - 2*W){prod[2*W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= first ? prod_ext : acc + prod_ext;
    end
  end

  assign result = W'(round_sat({{(RS_W - ACC_W){acc[ACC_W-1]}}, acc}, F_WIDTH, W));

endmodule

// File: rtl/mat_mult_lanes.sv
// rtl/mat_mult_lanes.sv - LANES-wide C = A x B / A x B^T sequencer with operand fetch and result backpressure
module mat_mult_lanes
  import mat_mult_lanes_pkg::*;
#(
  parameter int I_WIDTH = 16,
  parameter int F_WIDTH = 16,
  parameter int MAX_DIM = 103,
  parameter int LANES   = 4,
  localparam int W      = I_WIDTH + F_WIDTH,
  localparam int DIM_W  = dim_w(MAX_DIM),
  localparam int ACC_W  = acc_w(W, DIM_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 transpose_b,
  input  logic [DIM_W-1:0]     m_last,
  input  logic [DIM_W-1:0]     k_last,
  input  logic [DIM_W-1:0]     n_last,
  output logic                 rd_addr_valid,
  input  logic                 rd_addr_ready,
  output logic [DIM_W-1:0]     a_row,
  output logic [DIM_W-1:0]     a_col,
  output logic [DIM_W-1:0]     b_row,
  output logic [DIM_W-1:0]     b_col,
  input  logic                 opd_valid,
  output logic                 opd_ready,
  input  logic [W-1:0]         opd_a,
  input  logic [LANES*W-1:0]   opd_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_data,
  output logic [LANES-1:0]     out_lane_mask,
  output logic [DIM_W-1:0]     out_row,
  output logic [DIM_W-1:0]     out_col,
  output logic                 busy,
  output logic                 done
);

  state_t           state;
  logic             tr_q;
  logic [DIM_W-1:0] m_last_q, k_last_q, n_last_q;
  logic [DIM_W-1:0] a_i, a_j, a_k;
  logic [DIM_W-1:0] c_i, c_j, c_k;
  logic             pend_valid, pend_last, out_last;
  logic [DIM_W-1:0] pend_row, pend_col;
  logic [LANES-1:0] pend_mask;
  logic [W-1:0]     lane_res [LANES];
  logic             addr_fire, opd_fire, out_fire, c_done, load;

  function automatic logic blk_end(input logic [DIM_W-1:0] j0);
    return (int'(j0) + LANES > int'(n_last_q));
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [DIM_W-1:0] j0);
    logic [LANES-1:0] m;
    m = '0;
    for (int l = 0; l < LANES; l++) m[l] = (int'(j0) + l <= int'(n_last_q));
    return m;
  endfunction

  assign addr_fire = rd_addr_valid & rd_addr_ready;
  assign opd_fire  = opd_valid & opd_ready;
  assign out_fire  = out_valid & out_ready;
  assign c_done    = (c_k == k_last_q);
  // The pending beat always lands in the output register before a new completing beat is accepted.
  assign load      = pend_valid & (~out_valid | out_ready);
  assign busy      = (state == ST_RUN);
  assign opd_ready = busy & ~(c_done & out_valid & ~out_ready);
  assign done      = busy & out_fire & out_last;
  assign a_row     = a_i;
  assign a_col     = a_k;
  assign b_row     = tr_q ? a_j : a_k;
  assign b_col     = tr_q ? a_k : a_j;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mat_mult_lane_mac #(.W(W), .ACC_W(ACC_W), .F_WIDTH(F_WIDTH)) u_mac (
      .clk    (clk),
      .rst    (rst),
      .en     (opd_fire),
      .first  (c_k == '0),
      .a      (opd_a),
      .b      (opd_b[l*W +: W]),
      .result (lane_res[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      tr_q          <= 1'b0;
      m_last_q      <= '0;
      k_last_q      <= '0;
      n_last_q      <= '0;
      a_i           <= '0;
      a_j           <= '0;
      a_k           <= '0;
      c_i           <= '0;
      c_j           <= '0;
      c_k           <= '0;
      rd_addr_valid <= 1'b0;
      pend_valid    <= 1'b0;
      pend_last     <= 1'b0;
      pend_row      <= '0;
      pend_col      <= '0;
      pend_mask     <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_data      <= '0;
      out_lane_mask <= '0;
      out_row       <= '0;
      out_col       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_RUN;
            tr_q          <= transpose_b;
            m_last_q      <= m_last;
            k_last_q      <= k_last;
            n_last_q      <= n_last;
            a_i           <= '0;
            a_j           <= '0;
            a_k           <= '0;
            c_i           <= '0;
            c_j           <= '0;
            c_k           <= '0;
            rd_addr_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (addr_fire) begin
            if (a_k != k_last_q) begin
              a_k <= a_k + 1'b1;
            end else begin
              a_k <= '0;
              if (!blk_end(a_j)) begin
                a_j <= DIM_W'(int'(a_j) + LANES);
              end else begin
                a_j <= '0;
                if (a_i != m_last_q) a_i <= a_i + 1'b1;
                else rd_addr_valid <= 1'b0;
              end
            end
          end

          if (opd_fire) begin
            if (!c_done) begin
              c_k <= c_k + 1'b1;
            end else begin
              c_k <= '0;
              if (!blk_end(c_j)) begin
                c_j <= DIM_W'(int'(c_j) + LANES);
              end else begin
                c_j <= '0;
                if (c_i != m_last_q) c_i <= c_i + 1'b1;
              end
            end
          end

          if (out_fire) out_valid <= 1'b0;
          if (load) begin
            pend_valid    <= 1'b0;
            out_valid     <= 1'b1;
            out_last      <= pend_last;
            out_row       <= pend_row;
            out_col       <= pend_col;
            out_lane_mask <= pend_mask;
            for (int l = 0; l < LANES; l++)
              out_data[l*W +: W] <= pend_mask[l] ? lane_res[l] : '0;
          end
          if (opd_fire && c_done) begin
            pend_valid <= 1'b1;
            pend_row   <= c_i;
            pend_col   <= c_j;
            pend_mask  <= lane_mask(c_j);
            pend_last  <= (c_i == m_last_q) && blk_end(c_j);
          end

          if (done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_lanes.sv
// tb/tb_mat_mult_lanes.sv - scoreboard bench for mat_mult_lanes
module tb_mat_mult_lanes;

  localparam int W     = 32;
  localparam int LANES = 4;
  localparam int DW    = 7;
  localparam int BW    = LANES * W;

  typedef struct {
    int ar;
    int ac;
    int br;
    int bc;
  } addr_t;

  typedef struct {
    int             row;
    int             col;
    logic [BW-1:0]  data;
    logic [LANES-1:0] mask;
    bit             last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            transpose_b = 1'b0;
  logic [DW-1:0]   m_last = '0, k_last = '0, n_last = '0;
  logic            rd_addr_valid;
  logic            rd_addr_ready = 1'b0;
  logic [DW-1:0]   a_row, a_col, b_row, b_col;
  logic            opd_valid = 1'b0;
  logic            opd_ready;
  logic [W-1:0]    opd_a = '0;
  logic [BW-1:0]   opd_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [BW-1:0]   out_data;
  logic [LANES-1:0] out_lane_mask;
  logic [DW-1:0]   out_row, out_col;
  logic            busy, done;

  logic [W-1:0] amem [0:15][0:15];
  logic [W-1:0] bmem [0:15][0:15];
  addr_t addr_q[$];
  addr_t rsp_q[$];
  beat_t sb_q[$];
  int n_vec = 0, n_miscmp = 0;
  int cons_n = 0, done_cnt = 0, stall_cnt = 0, klast = 0;
  bit gap_en = 1'b1;

  always #5 clk = ~clk;

  mat_mult_lanes #(.I_WIDTH(16), .F_WIDTH(16), .MAX_DIM(103), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .start(start), .transpose_b(transpose_b),
    .m_last(m_last), .k_last(k_last), .n_last(n_last),
    .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready),
    .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
    .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_a(opd_a), .opd_b(opd_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane_mask(out_lane_mask), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] pack_addr(input int ar, input int ac, input int br, input int bc);
    return {DW'(ar), DW'(ac), DW'(br), DW'(bc)};
  endfunction

  function automatic logic [W-1:0] rnd_sat(input longint s);
    longint r;
    r = (s + 64'sd32768) >>> 16;
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] bval(input int kk, input int j, input bit tr);
    return tr ? bmem[j][kk] : bmem[kk][j];
  endfunction

  function automatic logic [W-1:0] small_val();
    return W'(int'($urandom_range(0, 2 ** 19)) - 2 ** 18);
  endfunction

  task automatic fill_junk();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        amem[r][c] = $urandom;
        bmem[r][c] = $urandom;
      end
  endtask

  task automatic fill_small(input int m, input int k, input int n, input bit tr);
    fill_junk();
    for (int i = 0; i <= m; i++)
      for (int kk = 0; kk <= k; kk++) amem[i][kk] = small_val();
    for (int kk = 0; kk <= k; kk++)
      for (int j = 0; j <= n; j++)
        if (tr) bmem[j][kk] = small_val();
        else bmem[kk][j] = small_val();
  endtask

  task automatic build_expect(input int m, input int k, input int n, input bit tr);
    beat_t  e;
    longint s;
    for (int i = 0; i <= m; i++)
      for (int j0 = 0; j0 <= n; j0 += LANES) begin
        for (int kk = 0; kk <= k; kk++)
          addr_q.push_back('{ar: i, ac: kk, br: tr ? j0 : kk, bc: tr ? kk : j0});
        e.row  = i;
        e.col  = j0;
        e.data = '0;
        e.mask = '0;
        for (int l = 0; l < LANES; l++)
          if (j0 + l <= n) begin
            s = 0;
            for (int kk = 0; kk <= k; kk++)
              s += longint'($signed(amem[i][kk])) * longint'($signed(bval(kk, j0 + l, tr)));
            e.data[l*W +: W] = rnd_sat(s);
            e.mask[l] = 1'b1;
          end
        e.last = (i == m) && (j0 + LANES > n);
        sb_q.push_back(e);
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {rd_addr_valid, opd_ready, out_valid, busy, done}, '0);
    check_eq({tag, "_data"}, out_data, '0);
    check_eq({tag, "_mask"}, out_lane_mask, '0);
    check_eq({tag, "_idx"}, {a_row, a_col, b_row, b_col, out_row, out_col}, '0);
  endtask

  task automatic run_case(input int m, input int k, input int n, input bit tr, input bit bp, input bit abort);
    bit bp_used;
    bp_used = 1'b0;
    build_expect(m, k, n, tr);
    klast = k; cons_n = 0; done_cnt = 0; stall_cnt = 0;
    gap_en = !bp;
    m_last = DW'(m); k_last = DW'(k); n_last = DW'(n); transpose_b = tr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (abort) begin
      for (int c = 0; c < 500 && cons_n < 2; c++) begin @(posedge clk); #1; end
      check_eq("abort_reach", cons_n >= 2, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("abort");
      check_eq("abort_done", done_cnt, 0);
      return;
    end
    for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
      if (bp && !bp_used && out_valid) begin
        bp_used = 1'b1;
        out_ready = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check_eq("done_cnt", done_cnt, 1);
    check_eq("sb_left", sb_q.size(), 0);
    check_eq("addr_left", addr_q.size(), 0);
    check_eq("idle_after", busy, 0);
    if (bp) check_eq("stall_seen", stall_cnt > 0, 1);
  endtask

  // Monitor and operand responder: observe handshakes at negedge, drive after posedge.
  initial begin
    addr_t a, r;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_q.delete(); addr_q.delete(); sb_q.delete();
        cons_n = 0;
      end else begin
        if (rd_addr_valid && rd_addr_ready) begin
          if (addr_q.size() == 0) check_eq("addr_extra", 1, 0);
          else begin
            a = addr_q.pop_front();
            check_eq("addr", {a_row, a_col, b_row, b_col}, pack_addr(a.ar, a.ac, a.br, a.bc));
          end
          rsp_q.push_back('{ar: int'(a_row), ac: int'(a_col), br: int'(b_row), bc: int'(b_col)});
        end
        if (opd_valid && opd_ready) begin
          void'(rsp_q.pop_front());
          cons_n++;
        end else if (opd_valid && busy) begin
          stall_cnt++;
          check_eq("stall_k", cons_n % (klast + 1), klast);
        end
        if (out_valid) begin
          if (sb_q.size() == 0) check_eq("out_extra", 1, 0);
          else if (out_ready) begin
            e = sb_q.pop_front();
            check_eq("out_data", out_data, e.data);
            check_eq("out_mask", out_lane_mask, e.mask);
            check_eq("out_pos", {out_row, out_col}, {DW'(e.row), DW'(e.col)});
            check_eq("done", done, e.last);
          end else begin
            check_eq("hold_data", out_data, sb_q[0].data);
          end
        end
        if (done) done_cnt++;
      end
      @(posedge clk); #1;
      rd_addr_ready = ($urandom_range(0, 3) != 0);
      if (rsp_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
        r = rsp_q[0];
        opd_valid = 1'b1;
        opd_a = amem[r.ar][r.ac];
        for (int l = 0; l < LANES; l++)
          opd_b[l*W +: W] = transpose_b ? bmem[r.br + l][r.bc] : bmem[r.br][r.bc + l];
      end else begin
        opd_valid = 1'b0;
      end
    end
  end

  task automatic load_identity(input bit tr);
    logic [W-1:0] bv [0:2][0:1];
    fill_junk();
    amem[0][0] = 32'h0001_0000; amem[0][1] = 32'h0002_0000; amem[0][2] = 32'h0003_0000;
    amem[1][0] = 32'h0004_0000; amem[1][1] = 32'h0005_0000; amem[1][2] = 32'h0006_0000;
    bv[0][0] = 32'h0001_0000; bv[0][1] = 32'h0000_0000;
    bv[1][0] = 32'h0000_0000; bv[1][1] = 32'h0001_0000;
    bv[2][0] = 32'h0001_0000; bv[2][1] = 32'h0001_0000;
    for (int kk = 0; kk < 3; kk++)
      for (int j = 0; j < 2; j++)
        if (tr) bmem[j][kk] = bv[kk][j];
        else bmem[kk][j] = bv[kk][j];
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    load_identity(1'b0);
    run_case(1, 2, 1, 1'b0, 1'b0, 1'b0);
    load_identity(1'b1);
    run_case(1, 2, 1, 1'b1, 1'b0, 1'b0);

    fill_small(1, 1, 5, 1'b0);
    run_case(1, 1, 5, 1'b0, 1'b0, 1'b0);

    fill_junk();
    amem[0][0] = 32'h7FFF_0000; bmem[0][0] = 32'h7FFF_0000;
    run_case(0, 0, 0, 1'b0, 1'b0, 1'b0);
    amem[0][0] = 32'h8001_0000;
    run_case(0, 0, 0, 1'b0, 1'b0, 1'b0);

    fill_small(1, 1, 5, 1'b1);
    run_case(1, 1, 5, 1'b1, 1'b1, 1'b0);
    fill_small(2, 0, 6, 1'b0);
    run_case(2, 0, 6, 1'b0, 1'b1, 1'b0);

    fill_small(1, 2, 5, 1'b0);
    run_case(1, 2, 5, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    load_identity(1'b0);
    run_case(1, 2, 1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
